switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions raw board slide-switch inputs before the switches peripheral register captures them.
//  Per bit: 2-FF synchroniser, then a stability counter clocked by a shared sample tick.
//  Drives the debounced vector into the switches register's data input.
//  Also flags edges for software via per-bit rise/fall pulses and a sticky change interrupt.
// PARAMETERS
//  NUM_SW          32      number of switch inputs; width of all vector ports
//  SAMPLE_DIV      50000   iClk cycles per sample tick (>=1); 1 = tick every cycle
//  STABLE_SAMPLES  10      consecutive differing ticks needed to accept a new level (>=1)
// PORTS
//  iClk            in   1       system clock, all logic on rising edge
//  iReset_n        in   1       asynchronous, active-low reset
//  iEnable         in   1       1 = debounce running; 0 = freeze debounced state
//  iSwitches_raw   in   NUM_SW  asynchronous raw switch pins
//  iIrq_ack        in   1       1-cycle pulse clears oChange_irq
//  oSwitches_data  out  NUM_SW  debounced, registered switch levels
//  oRise_pulse     out  NUM_SW  1-cycle pulse: bit i of oSwitches_data went 0->1
//  oFall_pulse     out  NUM_SW  1-cycle pulse: bit i of oSwitches_data went 1->0
//  oChange_irq     out  1       sticky: any debounced bit changed since last ack
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - sync stages, prescaler, all counters and all outputs go to 0.
//  Sync:
//   - sync1<=raw, sync2<=sync1 every cycle, independent of iEnable.
//  Prescaler:
//   - counts 0..SAMPLE_DIV-1 and wraps; tick=1 for one cycle when count==SAMPLE_DIV-1.
//   - SAMPLE_DIV=1: tick is constantly 1.
//   - iEnable=0: prescaler held at 0, no ticks.
//  Per bit i, on tick:
//   - sync2[i]==deb[i]: cnt[i]<=0 (a bounce restarts the count).
//   - differs, cnt[i]<STABLE_SAMPLES-1: cnt[i]++.
//   - differs, cnt[i]==STABLE_SAMPLES-1: deb[i]<=sync2[i], cnt[i]<=0.
//   - cnt width = clog2(STABLE_SAMPLES)+1; never exceeds STABLE_SAMPLES-1.
//  Hold conditions:
//   - no tick: deb and cnt hold.
//   - iEnable=0: cnt forced to 0, deb holds.
//  Latency (SAMPLE_DIV=1):
//   - raw change captured at edge 0; oSwitches_data shows new level after edge STABLE_SAMPLES+1.
//   - a raw pulse shorter than STABLE_SAMPLES cycles never reaches the output.
//  Edge pulses:
//   - registered in the same edge that updates deb.
//   - oRise_pulse[i]/oFall_pulse[i] are high exactly in the first cycle oSwitches_data[i] shows its new value.
//   - both pulses are 0 in all other cycles.
//   - several bits may pulse in the same cycle.
//  Interrupt:
//   - oChange_irq<=1 on any deb change.
//   - iIrq_ack clears it to 0.
//   - change and ack in the same cycle: set wins (irq stays 1).
//  Reset mid-operation:
//   - all state cleared immediately; no pulses or irq generated by the reset itself.
//   - switches held high at release re-debounce from 0 and produce rise pulses.
// TESTING (NUM_SW=32, SAMPLE_DIV=1, STABLE_SAMPLES=4 unless noted)
//  1 Reset: hold raw=32'hFFFF_FFFF during reset -> all outputs 0 throughout.
//    After release: data=FFFF_FFFF after edge 5, rise=FFFF_FFFF for exactly that cycle, irq=1.
//  2 Glitch: raw[3] high 3 cycles, then low -> oSwitches_data stays 0, no pulses, irq stays 0.
//  3 Bounce: raw[0] toggles 1,0,1 at 1-cycle spacing, then holds 1.
//    -> data[0]=1 exactly 5 edges after the final rise; single rise pulse.
//  4 Fall and ack: bit 7 debounced high, raw[7]->0.
//    -> fall[7] one cycle, irq=1; iIrq_ack -> irq 0 next cycle.
//    Ack coincident with a new change on bit 8 -> irq stays 1.
//  5 Prescaler: SAMPLE_DIV=3.
//    -> tick every 3rd cycle; raw[1] 0->1 reaches data[1] after 4 ticks; raw pulse of 9 cycles rejected.
//  6 Enable: iEnable=0 while raw[2] changes for 20 cycles -> data frozen.
//    Re-enable -> data[2] updates 4 ticks later; reset asserted mid-count -> outputs 0 immediately.

Source files
------------

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-FF synchroniser, shared sample-tick prescaler and per-bit
// stability counters, with registered debounced levels, rise/fall pulses and a sticky change irq.
module switch_debouncer #(
    parameter int NUM_SW         = 32,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 10
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iEnable,
    input  logic [NUM_SW-1:0] iSwitches_raw,
    input  logic              iIrq_ack,
    output logic [NUM_SW-1:0] oSwitches_data,
    output logic [NUM_SW-1:0] oRise_pulse,
    output logic [NUM_SW-1:0] oFall_pulse,
    output logic              oChange_irq
);

    localparam int CNT_W   = $clog2(STABLE_SAMPLES) + 1;
    localparam int PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    logic [NUM_SW-1:0]  sync1_q;
    logic [NUM_SW-1:0]  sync1_d;
    logic [NUM_SW-1:0]  sync2_q;
    logic [NUM_SW-1:0]  sync2_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick_s;
    logic [CNT_W-1:0]   cnt_q [NUM_SW];
    logic [CNT_W-1:0]   cnt_d [NUM_SW];
    logic [NUM_SW-1:0]  deb_q;
    logic [NUM_SW-1:0]  deb_d;
    logic [NUM_SW-1:0]  rise_q;
    logic [NUM_SW-1:0]  rise_d;
    logic [NUM_SW-1:0]  fall_q;
    logic [NUM_SW-1:0]  fall_d;
    logic               irq_q;
    logic               irq_d;
    logic               any_change_s;

    // Synchroniser chain runs every cycle regardless of iEnable.
    always_comb begin
        sync1_d = iSwitches_raw;
        sync2_d = sync1_q;
    end

    // Prescaler: wraps at SAMPLE_DIV-1 and is parked at zero while disabled.
    always_comb begin
        presc_d = PRESC_ZERO;
        tick_s  = 1'b0;
        if (iEnable) begin
            tick_s = (presc_q == PRESC_LAST);
            if (presc_q == PRESC_LAST) begin
                presc_d = PRESC_ZERO;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end else begin
            presc_d = PRESC_ZERO;
            tick_s  = 1'b0;
        end
    end

    // Per-bit stability counters; any sample agreeing with the current level restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (!iEnable) begin
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_d[i] = CNT_ZERO;
            end
        end else if (tick_s) begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_d[i] = CNT_ZERO;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = CNT_ZERO;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end else begin
            deb_d = deb_q;
        end
    end

    // Edge pulses and the sticky interrupt are registered alongside the debounced level.
    always_comb begin
        rise_d       = deb_d & ~deb_q;
        fall_d       = ~deb_d & deb_q;
        any_change_s = |(deb_d ^ deb_q);
        irq_d        = irq_q;
        if (any_change_s) begin
            irq_d = 1'b1;
        end else if (iIrq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // State register for synchroniser, prescaler, counters and all outputs.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            sync1_q <= {NUM_SW{1'b0}};
            sync2_q <= {NUM_SW{1'b0}};
            presc_q <= PRESC_ZERO;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            deb_q  <= {NUM_SW{1'b0}};
            rise_q <= {NUM_SW{1'b0}};
            fall_q <= {NUM_SW{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            for (int i = 0; i < NUM_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            irq_q  <= irq_d;
        end
    end

    assign oSwitches_data = deb_q;
    assign oRise_pulse    = rise_q;
    assign oFall_pulse    = fall_q;
    assign oChange_irq    = irq_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: a 1-cycle-tick and a 3-cycle-tick instance share stimulus and are
// compared every cycle against a timestamp-based reference model, plus directed scenario checks.
module tb_switch_debouncer;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] raw;
    logic        ack;

    logic [31:0] d1_data, d1_rise, d1_fall;
    logic        d1_irq;
    logic [31:0] d3_data, d3_rise, d3_fall;
    logic        d3_irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state: per instance, debounced level, pulses, irq, enabled-cycle count,
    // number of ticks seen, and the tick index at which each bit last agreed (or flipped).
    logic [31:0] m_s1, m_s2;
    logic [31:0] m_deb  [2];
    logic [31:0] m_rise [2];
    logic [31:0] m_fall [2];
    logic        m_irq  [2];
    int          m_ecount [2];
    int          m_ntick  [2];
    int          m_last   [2][32];

    always #5 clk = ~clk;

    switch_debouncer #(.NUM_SW(32), .SAMPLE_DIV(1), .STABLE_SAMPLES(STABLE)) u1 (
        .iClk(clk), .iReset_n(rst_n), .iEnable(en), .iSwitches_raw(raw), .iIrq_ack(ack),
        .oSwitches_data(d1_data), .oRise_pulse(d1_rise), .oFall_pulse(d1_fall), .oChange_irq(d1_irq)
    );

    switch_debouncer #(.NUM_SW(32), .SAMPLE_DIV(3), .STABLE_SAMPLES(STABLE)) u3 (
        .iClk(clk), .iReset_n(rst_n), .iEnable(en), .iSwitches_raw(raw), .iIrq_ack(ack),
        .oSwitches_data(d3_data), .oRise_pulse(d3_rise), .oFall_pulse(d3_fall), .oChange_irq(d3_irq)
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        m_s1 = 32'h0;
        m_s2 = 32'h0;
        for (int k = 0; k < 2; k++) begin
            m_deb[k]    = 32'h0;
            m_rise[k]   = 32'h0;
            m_fall[k]   = 32'h0;
            m_irq[k]    = 1'b0;
            m_ecount[k] = 0;
            m_ntick[k]  = 0;
            for (int i = 0; i < 32; i++) m_last[k][i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs as they stood just before the edge.
    task automatic model_edge();
        logic [31:0] nd;
        bit          tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            tick = en && ((m_ecount[k] % div_of(k)) == div_of(k) - 1);
            m_ecount[k] = en ? m_ecount[k] + 1 : 0;
            nd = m_deb[k];
            if (!en) begin
                for (int i = 0; i < 32; i++) m_last[k][i] = m_ntick[k];
            end else if (tick) begin
                m_ntick[k]++;
                for (int i = 0; i < 32; i++) begin
                    if (m_s2[i] != m_deb[k][i]) begin
                        if (m_ntick[k] - m_last[k][i] >= STABLE) begin
                            nd[i] = m_s2[i];
                            m_last[k][i] = m_ntick[k];
                        end
                    end else begin
                        m_last[k][i] = m_ntick[k];
                    end
                end
            end
            m_rise[k] = nd & ~m_deb[k];
            m_fall[k] = ~nd & m_deb[k];
            if (nd != m_deb[k]) m_irq[k] = 1'b1;
            else if (ack) m_irq[k] = 1'b0;
            m_deb[k] = nd;
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("u1_data", d1_data, m_deb[0]);
        chk("u1_rise", d1_rise, m_rise[0]);
        chk("u1_fall", d1_fall, m_fall[0]);
        chk("u1_irq", {31'h0, d1_irq}, {31'h0, m_irq[0]});
        chk("u3_data", d3_data, m_deb[1]);
        chk("u3_rise", d3_rise, m_rise[1]);
        chk("u3_fall", d3_fall, m_fall[1]);
        chk("u3_irq", {31'h0, d3_irq}, {31'h0, m_irq[1]});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic do_reset(input logic [31:0] raw_val);
        rst_n = 1'b0;
        raw   = raw_val;
        model_reset();
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        raw   = 32'hFFFF_FFFF;
        ack   = 1'b0;
        model_reset();

        // Reset held with all switches high: outputs stay 0, then all bits rise together.
        steps(3);
        chk("t1_rst_data", d1_data, 32'h0);
        rst_n = 1'b1;
        steps(5);
        chk("t1_data_pre", d1_data, 32'h0);
        step();
        chk("t1_data", d1_data, 32'hFFFF_FFFF);
        chk("t1_rise", d1_rise, 32'hFFFF_FFFF);
        chk("t1_irq", {31'h0, d1_irq}, 32'h1);
        step();
        chk("t1_rise_end", d1_rise, 32'h0);

        // Glitch of three cycles on bit 3 is rejected.
        do_reset(32'h0);
        steps(8);
        raw = 32'h8;
        steps(3);
        raw = 32'h0;
        steps(10);
        chk("t2_data", d1_data, 32'h0);
        chk("t2_irq", {31'h0, d1_irq}, 32'h0);

        // Bounce 1,0,1 on bit 0: level accepted six edges after the final rise is applied.
        raw = 32'h1;
        step();
        raw = 32'h0;
        step();
        raw = 32'h1;
        steps(5);
        chk("t3_data_pre", d1_data, 32'h0);
        step();
        chk("t3_data", d1_data, 32'h1);
        chk("t3_rise", d1_rise, 32'h1);

        // Fall on bit 7, ack clears irq, ack coincident with a change on bit 8 keeps irq set.
        raw = 32'h81;
        steps(8);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t4_ack0", {31'h0, d1_irq}, 32'h0);
        raw = 32'h01;
        steps(5);
        chk("t4_fall_pre", d1_fall, 32'h0);
        step();
        chk("t4_fall", d1_fall, 32'h80);
        chk("t4_irq", {31'h0, d1_irq}, 32'h1);
        step();
        chk("t4_fall_end", d1_fall, 32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t4_ack1", {31'h0, d1_irq}, 32'h0);
        raw = 32'h101;
        steps(5);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t4_coinc_data", d1_data, 32'h101);
        chk("t4_coinc_irq", {31'h0, d1_irq}, 32'h1);

        // Prescaler of 3: four ticks at edges 2,5,8,11; nine-cycle pulse on bit 4 rejected.
        do_reset(32'h2);
        steps(11);
        chk("t5_data_pre", d3_data, 32'h0);
        step();
        chk("t5_data", d3_data, 32'h2);
        chk("t5_rise", d3_rise, 32'h2);
        raw = 32'h12;
        steps(9);
        raw = 32'h2;
        steps(30);
        chk("t5_reject", d3_data, 32'h2);

        // Enable low freezes the debounced state; re-enable accepts after four ticks.
        en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            raw = {29'h0, $urandom_range(0, 1) == 1, 2'b10};
            step();
        end
        raw = 32'h6;
        steps(2);
        chk("t6_frozen", d1_data, 32'h2);
        en = 1'b1;
        steps(3);
        chk("t6_pre", d1_data, 32'h2);
        step();
        chk("t6_data", d1_data, 32'h6);

        // Reset mid-count clears everything immediately.
        raw = 32'h26;
        steps(3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t6_rst_data", d1_data, 32'h0);
        steps(2);
        rst_n = 1'b1;

        // Randomised phase: sparse single-bit flips, occasional bursts, random enable and ack.
        for (int j = 0; j < 600; j++) begin
            if ($urandom_range(0, 5) == 0) raw = raw ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 60) == 0) raw = raw ^ $urandom();
            en  = ($urandom_range(0, 24) != 0);
            ack = ($urandom_range(0, 9) == 0);
            step();
        end
        ack = 1'b0;
        en  = 1'b1;
        steps(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
